mac_acc_ctrl: RTL

Sequencing controller for the floating-point MAC accumulate loop. It accepts a stream of IEEE-754 single-precision products through a valid/ready handshake and issues each one to the shared pipelined FP adder (compare/shift, add, normalize) together with the running sum. It then waits out the adder latency before issuing the next operand, which prevents read-after-write hazards on the accumulator. It sits between the multiplier output stage and the adder pipeline and reports the final sum after a programmed number of products.

---
 rtl/mac_acc_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/mac_acc_ctrl.sv
// Accumulate-loop sequencer: feeds products plus the running sum to a pipelined FP adder, one issue in flight.
// Optional MAC_ACC_ZERO_BYPASS_EN: products with a zero exponent are consumed without an adder issue.
module mac_acc_ctrl #(
    parameter int ADD_LAT = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             add_go,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_res,
    output logic [31:0]      acc_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      acc;
    logic [31:0]      prod;
    logic [CNT_W-1:0] remain;
    logic [3:0]       wcnt;
    logic             accept;
    logic             bypass;
    logic             last;

    assign accept = (state == FETCH) && in_valid;
    assign last   = (remain == CNT_W'(1));

`ifdef MAC_ACC_ZERO_BYPASS_EN
    assign bypass = accept && (in_data[30:23] == 8'h00);
`else
    assign bypass = 1'b0;
`endif

    // prod only ever holds an issued product, so it doubles as the registered add_b
    assign add_b = prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (len == '0) ? DONE : FETCH;
            FETCH: if (accept) begin
                       if (bypass) state_nxt = last ? DONE : FETCH;
                       else        state_nxt = ISSUE;
                   end
            ISSUE: state_nxt = WAIT;
            WAIT:  if (wcnt == 4'd1) state_nxt = last ? DONE : FETCH;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == FETCH);
        add_go   = (state == ISSUE);
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            prod    <= '0;
            remain  <= '0;
            wcnt    <= '0;
            add_a   <= '0;
            acc_out <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc    <= '0;
                    remain <= len;
                end
                FETCH: if (accept) begin
                    if (bypass) begin
                        remain <= remain - CNT_W'(1);
                    end else begin
                        prod  <= in_data;
                        add_a <= acc;
                    end
                end
                ISSUE: wcnt <= 4'(ADD_LAT);
                WAIT: begin
                    wcnt <= wcnt - 4'd1;
                    // result lands in the last wait cycle; capture before the next issue
                    if (wcnt == 4'd1) begin
                        acc    <= add_res;
                        remain <= remain - CNT_W'(1);
                    end
                end
                DONE: acc_out <= acc;
                default: ;
            endcase
        end
    end

endmodule
